// File: rtl/soc_driver_ot_if.sv
// SoC request/response channel between the MMIO driver (master) and the SoC fabric (slave).
interface soc_driver_ot_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic              soc_req_val;
    logic              soc_req_rdy;
    logic              soc_req_cmd;
    logic [ADDR_W-1:0] soc_req_addr;
    logic [DATA_W-1:0] soc_req_data;
    logic              soc_resp_val;
    logic              soc_resp_rdy;
    logic              soc_resp_cmd;
    logic [ADDR_W-1:0] soc_resp_addr;
    logic [DATA_W-1:0] soc_resp_data;

    modport master (
        output soc_req_val, soc_req_cmd, soc_req_addr, soc_req_data, soc_resp_rdy,
        input  soc_req_rdy, soc_resp_val, soc_resp_cmd, soc_resp_addr, soc_resp_data
    );

    modport slave (
        input  soc_req_val, soc_req_cmd, soc_req_addr, soc_req_data, soc_resp_rdy,
        output soc_req_rdy, soc_resp_val, soc_resp_cmd, soc_resp_addr, soc_resp_data
    );
endinterface

// File: rtl/soc_driver_ot.sv
// Multi-outstanding MMIO driver: buffers user commands, issues them to the SoC with up to
// MAX_OT in flight, checks in-order responses, buffers read data and reports status.
module soc_driver_ot #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int CMD_DEPTH = 8,
    parameter int MAX_OT    = 4,
    parameter int TIMEOUT   = 1024,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              err_clr,
    input  logic              user_valid,
    output logic              user_ready,
    input  logic              user_cmd,
    input  logic [ADDR_W-1:0] user_addr,
    input  logic [DATA_W-1:0] user_wdata,
    output logic              user_rvalid,
    input  logic              user_rready,
    output logic [DATA_W-1:0] user_rdata,
    output logic [ADDR_W-1:0] status,
    output logic [CNT_W-1:0]  issued_cnt,
    output logic [CNT_W-1:0]  done_cnt,
    soc_driver_ot_if.master   soc
);

    localparam int CMD_AW = $clog2(CMD_DEPTH);
    localparam int OT_AW  = (MAX_OT > 1) ? $clog2(MAX_OT) : 1;
    localparam int OT_CW  = $clog2(MAX_OT + 1);
    localparam int SUM_W  = OT_CW + 2;
    localparam int TM_W   = $clog2(TIMEOUT + 1);

    localparam logic [63:0] PAT_TIMEOUT  = 64'hDEADDEAD_DEADDEAD;
    localparam logic [63:0] PAT_MISMATCH = 64'hEEEEEEEE_EEEEEEEE;
    localparam logic [63:0] PAT_BUSY     = 64'h55555555_55555555;
    localparam logic [63:0] PAT_DONE     = 64'hAAAAAAAA_AAAAAAAA;
    localparam logic [ADDR_W-1:0] ST_TIMEOUT  = PAT_TIMEOUT[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] ST_MISMATCH = PAT_MISMATCH[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] ST_BUSY     = PAT_BUSY[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] ST_DONE     = PAT_DONE[ADDR_W-1:0];

    // Storage arrays (no reset; validity is tracked by the pointers and counts)
    logic              cmd_cmd_mem  [CMD_DEPTH];
    logic [ADDR_W-1:0] cmd_addr_mem [CMD_DEPTH];
    logic [DATA_W-1:0] cmd_data_mem [CMD_DEPTH];
    logic              trk_cmd_mem  [MAX_OT];
    logic [ADDR_W-1:0] trk_addr_mem [MAX_OT];
    logic [DATA_W-1:0] rbuf_mem     [MAX_OT];

    logic [CMD_AW-1:0] cmd_wr_ptr_reg, cmd_rd_ptr_reg;
    logic [CMD_AW:0]   cmd_cnt_reg, cmd_cnt_next;
    logic [OT_AW-1:0]  trk_wr_ptr_reg, trk_rd_ptr_reg;
    logic [OT_AW-1:0]  rbuf_wr_ptr_reg, rbuf_rd_ptr_reg;
    logic [OT_CW-1:0]  rbuf_cnt_reg, rbuf_cnt_next;
    logic [OT_CW-1:0]  ot_reg, ot_next;

    logic              req_val_reg, req_val_next;
    logic              req_cmd_reg;
    logic [ADDR_W-1:0] req_addr_reg;
    logic [DATA_W-1:0] req_data_reg;
    logic              resp_rdy_reg;

    logic [TM_W-1:0]   timer_reg, timer_next;
    logic              to_err_reg, to_err_next;
    logic              mm_err_reg, mm_err_next;
    logic [ADDR_W-1:0] status_reg, status_next;
    logic [CNT_W-1:0]  issued_cnt_reg, issued_cnt_next;
    logic [CNT_W-1:0]  done_cnt_reg, done_cnt_next;

    logic              cmd_push, issue_load, req_accept, resp_accept;
    logic              trk_hit, trk_pop, rbuf_push, rbuf_pop, room_ok;
    logic [SUM_W-1:0]  ot_after;

    // Circular increment for the MAX_OT-deep queues
    function automatic logic [OT_AW-1:0] ot_inc(input logic [OT_AW-1:0] p);
        if (p == OT_AW'(MAX_OT - 1))
            return '0;
        return p + OT_AW'(1);
    endfunction

    assign user_ready  = !rst && (cmd_cnt_reg != (CMD_AW+1)'(CMD_DEPTH));
    assign user_rvalid = (rbuf_cnt_reg != '0);
    assign user_rdata  = rbuf_mem[rbuf_rd_ptr_reg];
    assign status      = status_reg;
    assign issued_cnt  = issued_cnt_reg;
    assign done_cnt    = done_cnt_reg;

    assign soc.soc_req_val  = req_val_reg;
    assign soc.soc_req_cmd  = req_cmd_reg;
    assign soc.soc_req_addr = req_addr_reg;
    assign soc.soc_req_data = req_data_reg;
    assign soc.soc_resp_rdy = resp_rdy_reg;

    always_comb begin
        cmd_push    = user_valid && user_ready;
        req_accept  = req_val_reg && soc.soc_req_rdy;
        resp_accept = soc.soc_resp_val && resp_rdy_reg;
        trk_hit     = (ot_reg != '0)
                   && (soc.soc_resp_cmd  == trk_cmd_mem[trk_rd_ptr_reg])
                   && (soc.soc_resp_addr == trk_addr_mem[trk_rd_ptr_reg]);
        trk_pop     = resp_accept && (ot_reg != '0);
        rbuf_push   = resp_accept && trk_hit && !soc.soc_resp_cmd;
        rbuf_pop    = user_rvalid && user_rready;

        // Reads reserve a buffer slot for every outstanding transaction, so a
        // returning read always has somewhere to land.
        ot_after = SUM_W'(ot_reg) + SUM_W'(req_accept);
        room_ok  = (ot_after < SUM_W'(MAX_OT))
                && (cmd_cmd_mem[cmd_rd_ptr_reg]
                    || ((ot_after + SUM_W'(rbuf_cnt_reg)) < SUM_W'(MAX_OT)));
        issue_load = start && !to_err_reg && !mm_err_reg && (cmd_cnt_reg != '0)
                  && (!req_val_reg || soc.soc_req_rdy) && room_ok;

        cmd_cnt_next  = cmd_cnt_reg + (CMD_AW+1)'(cmd_push) - (CMD_AW+1)'(issue_load);
        ot_next       = ot_reg + OT_CW'(req_accept) - OT_CW'(trk_pop);
        rbuf_cnt_next = rbuf_cnt_reg + OT_CW'(rbuf_push) - OT_CW'(rbuf_pop);
        req_val_next  = issue_load || (req_val_reg && !soc.soc_req_rdy);

        issued_cnt_next = issued_cnt_reg + CNT_W'(req_accept);
        done_cnt_next   = done_cnt_reg + CNT_W'(resp_accept);

        if (err_clr || resp_accept || (ot_reg == '0))
            timer_next = '0;
        else if (timer_reg < TM_W'(TIMEOUT))
            timer_next = timer_reg + TM_W'(1);
        else
            timer_next = timer_reg;

        // A new error event in the clearing cycle still wins over err_clr
        to_err_next = (to_err_reg && !err_clr) || (timer_next == TM_W'(TIMEOUT));
        mm_err_next = (mm_err_reg && !err_clr) || (resp_accept && !trk_hit);

        if (to_err_next)
            status_next = ST_TIMEOUT;
        else if (mm_err_next)
            status_next = ST_MISMATCH;
        else if ((cmd_cnt_next != '0) || req_val_next || (ot_next != '0))
            status_next = ST_BUSY;
        else if (done_cnt_next != '0)
            status_next = ST_DONE;
        else
            status_next = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_wr_ptr_reg  <= '0;
            cmd_rd_ptr_reg  <= '0;
            cmd_cnt_reg     <= '0;
            trk_wr_ptr_reg  <= '0;
            trk_rd_ptr_reg  <= '0;
            rbuf_wr_ptr_reg <= '0;
            rbuf_rd_ptr_reg <= '0;
            rbuf_cnt_reg    <= '0;
            ot_reg          <= '0;
            req_val_reg     <= 1'b0;
            req_cmd_reg     <= 1'b0;
            req_addr_reg    <= '0;
            req_data_reg    <= '0;
            resp_rdy_reg    <= 1'b0;
            timer_reg       <= '0;
            to_err_reg      <= 1'b0;
            mm_err_reg      <= 1'b0;
            status_reg      <= '0;
            issued_cnt_reg  <= '0;
            done_cnt_reg    <= '0;
        end else begin
            if (cmd_push)
                cmd_wr_ptr_reg <= cmd_wr_ptr_reg + CMD_AW'(1);
            if (issue_load) begin
                cmd_rd_ptr_reg <= cmd_rd_ptr_reg + CMD_AW'(1);
                req_cmd_reg    <= cmd_cmd_mem[cmd_rd_ptr_reg];
                req_addr_reg   <= cmd_addr_mem[cmd_rd_ptr_reg];
                req_data_reg   <= cmd_data_mem[cmd_rd_ptr_reg];
            end
            if (req_accept)
                trk_wr_ptr_reg <= ot_inc(trk_wr_ptr_reg);
            if (trk_pop)
                trk_rd_ptr_reg <= ot_inc(trk_rd_ptr_reg);
            if (rbuf_push)
                rbuf_wr_ptr_reg <= ot_inc(rbuf_wr_ptr_reg);
            if (rbuf_pop)
                rbuf_rd_ptr_reg <= ot_inc(rbuf_rd_ptr_reg);
            cmd_cnt_reg    <= cmd_cnt_next;
            rbuf_cnt_reg   <= rbuf_cnt_next;
            ot_reg         <= ot_next;
            req_val_reg    <= req_val_next;
            resp_rdy_reg   <= 1'b1;
            timer_reg      <= timer_next;
            to_err_reg     <= to_err_next;
            mm_err_reg     <= mm_err_next;
            status_reg     <= status_next;
            issued_cnt_reg <= issued_cnt_next;
            done_cnt_reg   <= done_cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (cmd_push) begin
            cmd_cmd_mem[cmd_wr_ptr_reg]  <= user_cmd;
            cmd_addr_mem[cmd_wr_ptr_reg] <= user_addr;
            cmd_data_mem[cmd_wr_ptr_reg] <= user_wdata;
        end
        if (req_accept) begin
            trk_cmd_mem[trk_wr_ptr_reg]  <= req_cmd_reg;
            trk_addr_mem[trk_wr_ptr_reg] <= req_addr_reg;
        end
        if (rbuf_push)
            rbuf_mem[rbuf_wr_ptr_reg] <= soc.soc_resp_data;
    end

endmodule

// File: tb/tb_soc_driver_ot.sv
// Bench for soc_driver_ot: acts as the SoC, scoreboards requests and read data, and walks
// through start gating, pipelining, read back-pressure, mismatch, timeout and reset cases.
module tb_soc_driver_ot;

    localparam logic [63:0] ST_TO   = 64'hDEADDEAD;
    localparam logic [63:0] ST_MM   = 64'hEEEEEEEE;
    localparam logic [63:0] ST_BUSY = 64'h55555555;
    localparam logic [63:0] ST_DONE = 64'hAAAAAAAA;

    logic        clk = 1'b0;
    logic        rst, start, err_clr;
    logic        user_valid, user_ready, user_cmd;
    logic [31:0] user_addr;
    logic [63:0] user_wdata;
    logic        user_rvalid, user_rready;
    logic [63:0] user_rdata;
    logic [31:0] status;
    logic [15:0] issued_cnt, done_cnt;
    logic        rdy_rand = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        cmd;
        logic [31:0] addr;
        logic [63:0] data;
    } req_t;

    typedef struct {
        logic        cmd;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
    } vec_t;

    req_t        req_exp_q[$];
    req_t        pend_q[$];
    logic [63:0] rexp_q[$];
    vec_t        tbl[8];

    soc_driver_ot_if #(.ADDR_W(32), .DATA_W(64)) soc_if ();

    soc_driver_ot #(
        .ADDR_W(32), .DATA_W(64), .CMD_DEPTH(8), .MAX_OT(4), .TIMEOUT(16), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .err_clr(err_clr),
        .user_valid(user_valid), .user_ready(user_ready), .user_cmd(user_cmd),
        .user_addr(user_addr), .user_wdata(user_wdata),
        .user_rvalid(user_rvalid), .user_rready(user_rready), .user_rdata(user_rdata),
        .status(status), .issued_cnt(issued_cnt), .done_cnt(done_cnt),
        .soc(soc_if.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Request and read-data monitor; the SoC model records every accepted request
    always @(posedge clk) begin
        if (!rst && soc_if.soc_req_val && soc_if.soc_req_rdy) begin
            req_t e;
            $display("req  cmd=%0d addr=%h data=%h", soc_if.soc_req_cmd, soc_if.soc_req_addr,
                     soc_if.soc_req_data);
            if (req_exp_q.size() == 0) begin
                bound_fail("req_unexpected");
            end else begin
                e = req_exp_q.pop_front();
                check("req_cmd", 64'(soc_if.soc_req_cmd), 64'(e.cmd));
                check("req_addr", 64'(soc_if.soc_req_addr), 64'(e.addr));
                check("req_data", soc_if.soc_req_data, e.data);
            end
            pend_q.push_back({soc_if.soc_req_cmd, soc_if.soc_req_addr, soc_if.soc_req_data});
        end
        if (!rst && user_rvalid && user_rready) begin
            $display("rpop data=%h", user_rdata);
            if (rexp_q.size() == 0)
                bound_fail("rdata_unexpected");
            else
                check("user_rdata", user_rdata, rexp_q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (rdy_rand)
            soc_if.soc_req_rdy = ($urandom_range(0, 1) == 1);
    end

    task automatic push_cmd(input logic c, input logic [31:0] a, input logic [63:0] d,
                            input logic [63:0] rd);
        int n = 0;
        user_valid = 1'b1;
        user_cmd   = c;
        user_addr  = a;
        user_wdata = d;
        while (!user_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!user_ready) begin
            bound_fail("push_wait");
            user_valid = 1'b0;
            return;
        end
        req_exp_q.push_back({c, a, d});
        if (!c)
            rexp_q.push_back(rd);
        @(negedge clk);
        user_valid = 1'b0;
        $display("push cmd=%0d addr=%h", c, a);
    endtask

    task automatic send_resp(input logic c, input logic [31:0] a, input logic [63:0] d);
        soc_if.soc_resp_val  = 1'b1;
        soc_if.soc_resp_cmd  = c;
        soc_if.soc_resp_addr = a;
        soc_if.soc_resp_data = d;
        @(negedge clk);
        soc_if.soc_resp_val = 1'b0;
        $display("resp cmd=%0d addr=%h data=%h", c, a, d);
    endtask

    task automatic wait_pend(output bit ok);
        int n = 0;
        while (pend_q.size() == 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = (pend_q.size() != 0);
        if (!ok)
            bound_fail("pend_wait");
    endtask

    // SoC memory model: read data is the address shifted right by four
    task automatic respond_n(input int cnt);
        bit   ok;
        req_t e;
        for (int i = 0; i < cnt; i++) begin
            wait_pend(ok);
            if (!ok)
                return;
            e = pend_q.pop_front();
            send_resp(e.cmd, e.addr, 64'(e.addr) >> 4);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   ok;
        req_t e;

        tbl[0] = '{1'b1, 32'h0000_0100, 64'h1111_2222_3333_4444, 64'h0};
        tbl[1] = '{1'b0, 32'h0000_0200, 64'h0,                   64'h20};
        tbl[2] = '{1'b1, 32'h0000_0300, 64'hFFFF_0000_FFFF_0000, 64'h0};
        tbl[3] = '{1'b0, 32'h0000_0400, 64'h0,                   64'h40};
        tbl[4] = '{1'b0, 32'h0000_0510, 64'h0,                   64'h51};
        tbl[5] = '{1'b1, 32'h0000_0600, 64'h0123_4567_89AB_CDEF, 64'h0};
        tbl[6] = '{1'b0, 32'h0000_07F0, 64'h0,                   64'h7F};
        tbl[7] = '{1'b0, 32'h0000_ABC0, 64'h0,                   64'hABC};

        rst = 1'b1; start = 1'b0; err_clr = 1'b0;
        user_valid = 1'b0; user_cmd = 1'b0; user_addr = '0; user_wdata = '0;
        user_rready = 1'b0;
        soc_if.soc_req_rdy = 1'b0; soc_if.soc_resp_val = 1'b0; soc_if.soc_resp_cmd = 1'b0;
        soc_if.soc_resp_addr = '0; soc_if.soc_resp_data = '0;
        tick(3);
        check("rst_user_ready", 64'(user_ready), 64'd0);
        check("rst_resp_rdy", 64'(soc_if.soc_resp_rdy), 64'd0);
        check("rst_req_val", 64'(soc_if.soc_req_val), 64'd0);
        check("rst_rvalid", 64'(user_rvalid), 64'd0);
        check("rst_status", 64'(status), 64'd0);
        check("rst_issued", 64'(issued_cnt), 64'd0);
        rst = 1'b0;
        tick(1);
        check("post_rst_user_ready", 64'(user_ready), 64'd1);
        check("post_rst_resp_rdy", 64'(soc_if.soc_resp_rdy), 64'd1);

        // Start gating
        push_cmd(1'b1, 32'h1000, 64'hABCD_ABCD_ABCD_ABCD, 64'h0);
        tick(5);
        check("gate_req_val", 64'(soc_if.soc_req_val), 64'd0);
        check("gate_status", 64'(status), ST_BUSY);
        start = 1'b1;
        tick(1);
        check("gate_show_val", 64'(soc_if.soc_req_val), 64'd1);
        check("gate_show_cmd", 64'(soc_if.soc_req_cmd), 64'd1);
        check("gate_show_addr", 64'(soc_if.soc_req_addr), 64'h1000);
        tick(2);
        check("gate_hold_addr", 64'(soc_if.soc_req_addr), 64'h1000);
        soc_if.soc_req_rdy = 1'b1;
        respond_n(1);
        tick(1);
        check("gate_status_done", 64'(status), ST_DONE);
        check("gate_issued", 64'(issued_cnt), 64'd1);
        check("gate_done", 64'(done_cnt), 64'd1);

        // Pipelining: only four outstanding while responses are withheld
        start = 1'b0;
        for (int i = 0; i < 6; i++)
            push_cmd(1'b1, 32'h2000 + 32'(i * 16), 64'hC0FFEE00 + 64'(i), 64'h0);
        start = 1'b1;
        tick(8);
        check("pipe_issued4", 64'(issued_cnt), 64'd5);
        check("pipe_req_held", 64'(soc_if.soc_req_val), 64'd0);
        check("pipe_status_busy", 64'(status), ST_BUSY);
        respond_n(6);
        tick(2);
        check("pipe_done", 64'(done_cnt), 64'd7);
        check("pipe_issued", 64'(issued_cnt), 64'd7);
        check("pipe_status_done", 64'(status), ST_DONE);

        // Reads with a full read buffer block the fifth read
        fork
            begin
                for (int i = 0; i < 5; i++)
                    push_cmd(1'b0, 32'(16 * (i + 1)), 64'h0, 64'(i + 1));
            end
            respond_n(4);
        join
        tick(4);
        check("rd_block_issued", 64'(issued_cnt), 64'd11);
        check("rd_block_val", 64'(soc_if.soc_req_val), 64'd0);
        check("rd_rvalid", 64'(user_rvalid), 64'd1);
        check("rd_head", user_rdata, 64'd1);
        check("rd_status_busy", 64'(status), ST_BUSY);
        user_rready = 1'b1;
        respond_n(1);
        tick(4);
        check("rd_all_popped", 64'(rexp_q.size()), 64'd0);
        check("rd_rvalid_empty", 64'(user_rvalid), 64'd0);
        check("rd_issued", 64'(issued_cnt), 64'd12);
        check("rd_done", 64'(done_cnt), 64'd12);

        // Mismatch halts issue until err_clr
        push_cmd(1'b1, 32'h1000, 64'h11, 64'h0);
        push_cmd(1'b1, 32'h3000, 64'h33, 64'h0);
        wait_pend(ok);
        if (ok) begin
            e = pend_q.pop_front();
            send_resp(1'b1, 32'h2000, 64'h0);
        end
        tick(2);
        check("mm_status", 64'(status), ST_MM);
        push_cmd(1'b1, 32'h4000, 64'h44, 64'h0);
        tick(4);
        check("mm_halt_val", 64'(soc_if.soc_req_val), 64'd0);
        check("mm_halt_issued", 64'(issued_cnt), 64'd14);
        respond_n(1);
        tick(1);
        check("mm_sticky", 64'(status), ST_MM);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("mm_clr_busy", 64'(status), ST_BUSY);
        respond_n(1);
        tick(2);
        check("mm_resume_status", 64'(status), ST_DONE);
        check("mm_resume_issued", 64'(issued_cnt), 64'd15);
        check("mm_resume_done", 64'(done_cnt), 64'd15);

        // Timeout on the 16th cycle after accept, mismatch latched underneath
        push_cmd(1'b1, 32'h5000, 64'h55, 64'h0);
        wait_pend(ok);
        tick(15);
        check("to_before", 64'(status), ST_BUSY);
        tick(1);
        check("to_hit", 64'(status), ST_TO);
        respond_n(1);
        tick(1);
        send_resp(1'b1, 32'h6000, 64'h0);
        tick(1);
        check("to_sticky", 64'(status), ST_TO);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("to_clr_done", 64'(status), ST_DONE);
        check("to_done_cnt", 64'(done_cnt), 64'd17);

        // Table-driven mixed traffic with random request back-pressure
        rdy_rand = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    push_cmd(tbl[i].cmd, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rdata);
            end
            respond_n(8);
        join
        rdy_rand = 1'b0;
        soc_if.soc_req_rdy = 1'b1;
        tick(5);
        check("tbl_rexp_empty", 64'(rexp_q.size()), 64'd0);
        check("tbl_req_empty", 64'(req_exp_q.size()), 64'd0);
        check("tbl_issued", 64'(issued_cnt), 64'd24);
        check("tbl_done", 64'(done_cnt), 64'd25);
        check("tbl_status", 64'(status), ST_DONE);

        // Full FIFO, then reset mid-traffic
        start = 1'b0;
        for (int i = 0; i < 8; i++)
            push_cmd(1'b1, 32'h8000 + 32'(i * 4), 64'(i), 64'h0);
        check("full_user_ready", 64'(user_ready), 64'd0);
        check("full_status", 64'(status), ST_BUSY);
        soc_if.soc_req_rdy = 1'b0;
        start = 1'b1;
        tick(2);
        check("full_req_val", 64'(soc_if.soc_req_val), 64'd1);
        rst = 1'b1;
        tick(1);
        check("mid_rst_user_ready", 64'(user_ready), 64'd0);
        check("mid_rst_resp_rdy", 64'(soc_if.soc_resp_rdy), 64'd0);
        check("mid_rst_req_val", 64'(soc_if.soc_req_val), 64'd0);
        check("mid_rst_req_addr", 64'(soc_if.soc_req_addr), 64'd0);
        check("mid_rst_status", 64'(status), 64'd0);
        check("mid_rst_issued", 64'(issued_cnt), 64'd0);
        check("mid_rst_done", 64'(done_cnt), 64'd0);
        req_exp_q.delete();
        pend_q.delete();
        rexp_q.delete();
        rst = 1'b0;
        soc_if.soc_req_rdy = 1'b1;
        tick(1);
        check("after_rst_user_ready", 64'(user_ready), 64'd1);
        tick(3);
        check("after_rst_fifo_empty_val", 64'(soc_if.soc_req_val), 64'd0);
        check("after_rst_status", 64'(status), 64'd0);
        check("after_rst_issued", 64'(issued_cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
